// File: rtl/sha_msg_schedule.sv
// sha_msg_schedule
// Message-schedule generator shared by the SHA cores. One padded 1024-bit
// block is accepted, then the expanded schedule words W[t] are streamed out
// one per output handshake. Supports SHA-1 (80 x 32-bit), SHA-224/256
// (64 x 32-bit) and SHA-384/512/512_224/512_256 (80 x 64-bit).
//
// Mode encoding (in_mode):
//   0 SHA-1, 1 SHA-224, 2 SHA-256, 3 SHA-384, 4 SHA-512,
//   5 SHA-512/224, 6 SHA-512/256, 7 reserved (rejected)
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   in_valid   block offered
//   in_ready   block accepted when in_valid & in_ready
//   in_mode    mode of the offered block
//   in_msg     padded message block (32-bit modes use [511:0])
//   abort      drop the current block and return to idle
//   out_valid  W word valid
//   out_ready  consumer takes the word
//   out_w      W[t]; 32-bit modes drive [63:32] = 0
//   out_t      round index t
//   out_last   t is the final round (63 or 79)
//   err        one-cycle pulse when an unsupported mode is rejected
module sha_msg_schedule #(
    parameter int ENABLE_SHA1   = 1,
    parameter int ENABLE_SHA512 = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_mode,
    input  logic [1023:0] in_msg,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_w,
    output logic [6:0]    out_t,
    output logic          out_last,
    output logic          err
);

    localparam logic [2:0] MODE_SHA1   = 3'd0;
    localparam logic [2:0] MODE_SHA224 = 3'd1;
    localparam logic [2:0] MODE_SHA256 = 3'd2;
    localparam logic [2:0] MODE_SHA384 = 3'd3;
    localparam logic [2:0] MODE_MAX    = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [63:0]  r_buf [16];
    logic [2:0]   r_mode;
    logic [6:0]   r_t;
    logic         r_err;

    logic         w_accept;
    logic         w_mode_ok;
    logic         w_advance;
    logic         w_last_hs;
    logic [63:0]  w_new;

    // ------------------------------------------------------------------
    // Mode helpers and SHA-2 small sigma functions
    // ------------------------------------------------------------------
    function automatic logic mode_is64(input logic [2:0] m);
        return (m >= MODE_SHA384);
    endfunction

    function automatic logic mode_supported(input logic [2:0] m);
        logic ok;
        ok = 1'b1;
        if (m > MODE_MAX)
            ok = 1'b0;
        else if (m == MODE_SHA1)
            ok = (ENABLE_SHA1 != 0);
        else if (mode_is64(m))
            ok = (ENABLE_SHA512 != 0);
        return ok;
    endfunction

    function automatic logic [31:0] delta0_32(input logic [31:0] x);
        return ({x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3));
    endfunction

    function automatic logic [31:0] delta1_32(input logic [31:0] x);
        return ({x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10));
    endfunction

    function automatic logic [63:0] delta0_64(input logic [63:0] x);
        return ({x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7));
    endfunction

    function automatic logic [63:0] delta1_64(input logic [63:0] x);
        return ({x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6));
    endfunction

    // ------------------------------------------------------------------
    // Handshake and output decode
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (r_state == ST_RUN);
        out_last  = out_valid &&
                    (r_t == (((r_mode == MODE_SHA224) || (r_mode == MODE_SHA256)) ? 7'd63 : 7'd79));
        out_w     = r_buf[0];
        out_t     = r_t;
        err       = r_err;
        // Ready on the final beat's handshake so the next block follows with no bubble.
        in_ready  = (r_state == ST_IDLE) | (out_valid & out_last & out_ready);
        w_accept  = in_valid & in_ready & ~abort;
        w_mode_ok = mode_supported(in_mode);
        w_last_hs = out_valid & out_ready & out_last;
        w_advance = out_valid & out_ready & ~out_last & ~abort;
    end

    // ------------------------------------------------------------------
    // Next schedule word from the current window: buf[i] holds W[t+i],
    // so the new entry is W[t+16].
    // ------------------------------------------------------------------
    always_comb begin
        w_new = '0;
        if ((ENABLE_SHA1 != 0) && (r_mode == MODE_SHA1)) begin
            w_new[31:0] = {r_buf[13][30:0] ^ r_buf[8][30:0] ^ r_buf[2][30:0] ^ r_buf[0][30:0],
                           r_buf[13][31]   ^ r_buf[8][31]   ^ r_buf[2][31]   ^ r_buf[0][31]};
        end else if ((ENABLE_SHA512 != 0) && mode_is64(r_mode)) begin
            w_new = delta1_64(r_buf[14]) + r_buf[9] + delta0_64(r_buf[1]) + r_buf[0];
        end else begin
            w_new[31:0] = delta1_32(r_buf[14][31:0]) + r_buf[9][31:0] +
                          delta0_32(r_buf[1][31:0]) + r_buf[0][31:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (abort)
            w_state_next = ST_IDLE;
        else if (w_accept)
            w_state_next = w_mode_ok ? ST_RUN : ST_IDLE;
        else if (w_last_hs)
            w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // ------------------------------------------------------------------
    // Shift buffer, round counter, mode latch, error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                r_buf[i] <= '0;
            r_mode <= MODE_SHA1;
            r_t    <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_mode_ok;
            if (abort) begin
                r_t <= '0;
            end else if (w_accept && w_mode_ok) begin
                for (int i = 0; i < 16; i++) begin
                    if (mode_is64(in_mode))
                        r_buf[i] <= in_msg[1023 - 64*i -: 64];
                    else
                        r_buf[i] <= {32'b0, in_msg[511 - 32*i -: 32]};
                end
                r_mode <= in_mode;
                r_t    <= '0;
            end else if (w_advance) begin
                for (int i = 0; i < 15; i++)
                    r_buf[i] <= r_buf[i+1];
                r_buf[15] <= w_new;
                r_t       <= r_t + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha_msg_schedule.sv
module tb_sha_msg_schedule;

    localparam logic [2:0] M_SHA1 = 3'd0;
    localparam logic [2:0] M_224  = 3'd1;
    localparam logic [2:0] M_256  = 3'd2;
    localparam logic [2:0] M_384  = 3'd3;
    localparam logic [2:0] M_512  = 3'd4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, abort, out_valid, out_ready, out_last, err;
    logic [2:0]    in_mode;
    logic [1023:0] in_msg;
    logic [63:0]   out_w;
    logic [6:0]    out_t;

    logic          b_in_valid, b_in_ready, b_abort, b_out_valid, b_out_ready, b_out_last, b_err;
    logic [2:0]    b_in_mode;
    logic [1023:0] b_in_msg;
    logic [63:0]   b_out_w;
    logic [6:0]    b_out_t;

    sha_msg_schedule dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_msg(in_msg), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
        .out_t(out_t), .out_last(out_last), .err(err)
    );

    sha_msg_schedule #(.ENABLE_SHA1(1), .ENABLE_SHA512(0)) dut_n512 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_msg(b_in_msg), .abort(b_abort),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_w(b_out_w),
        .out_t(b_out_t), .out_last(b_out_last), .err(b_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (FIPS 180-4 recurrences) ----------------
    logic [63:0] ref_w [80];
    int          ref_n;
    logic [63:0] cap   [80];

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic build_model(input logic [2:0] mode, input logic [1023:0] msg);
        logic [31:0] x;
        logic [63:0] s0, s1;
        ref_n = (mode == M_224 || mode == M_256) ? 64 : 80;
        for (int t = 0; t < 16; t++) begin
            if (mode >= M_384) ref_w[t] = msg[1023 - 64*t -: 64];
            else               ref_w[t] = {32'b0, msg[511 - 32*t -: 32]};
        end
        for (int t = 16; t < 80; t++) begin
            if (mode == M_SHA1) begin
                x = ref_w[t-3][31:0] ^ ref_w[t-8][31:0] ^ ref_w[t-14][31:0] ^ ref_w[t-16][31:0];
                ref_w[t] = {32'b0, rotr32(x, 31)};
            end else if (mode >= M_384) begin
                s0 = rotr64(ref_w[t-15], 1) ^ rotr64(ref_w[t-15], 8) ^ (ref_w[t-15] >> 7);
                s1 = rotr64(ref_w[t-2], 19) ^ rotr64(ref_w[t-2], 61) ^ (ref_w[t-2] >> 6);
                ref_w[t] = s1 + ref_w[t-7] + s0 + ref_w[t-16];
            end else begin
                x = rotr32(ref_w[t-2][31:0], 17) ^ rotr32(ref_w[t-2][31:0], 19) ^ (ref_w[t-2][31:0] >> 10);
                x = x + ref_w[t-7][31:0] + ref_w[t-16][31:0] +
                    (rotr32(ref_w[t-15][31:0], 7) ^ rotr32(ref_w[t-15][31:0], 18) ^ (ref_w[t-15][31:0] >> 3));
                ref_w[t] = {32'b0, x};
            end
        end
    endtask

    // ---------------- known-answer table ("abc" blocks) ----------------
    typedef struct {
        logic [2:0]  mode;
        int          t;
        logic [63:0] w;
    } vec_t;
    vec_t vecs [10];

    task automatic apply_table(input logic [2:0] mode);
        for (int i = 0; i < 10; i++)
            if (vecs[i].mode == mode)
                chk($sformatf("kat_m%0d_W%0d", mode, vecs[i].t), cap[vecs[i].t], vecs[i].w);
    endtask

    function automatic logic [1023:0] rand_msg();
        logic [1023:0] m;
        for (int k = 0; k < 32; k++) m[32*k +: 32] = $urandom;
        return m;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic offer(input logic [2:0] mode, input logic [1023:0] msg);
        in_mode = mode; in_msg = msg; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int rdy_pct, input bit chain,
                           input logic [2:0] nmode, input logic [1023:0] nmsg);
        int          beat;
        bit          stalled, done, lastb;
        logic [63:0] pw;
        logic [6:0]  pt;
        beat = 0; stalled = 0; done = 0; pw = '0; pt = '0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            lastb = (beat == ref_n - 1);
            chk("out_valid", out_valid, 1);
            if (stalled) begin
                chk("stall_w", out_w, pw);
                chk("stall_t", out_t, pt);
            end
            chk("in_ready", in_ready, lastb && out_ready);
            if (out_ready && beat < 80) begin
                chk($sformatf("w[%0d]", beat), out_w, ref_w[beat]);
                chk("t", out_t, beat);
                chk("last", out_last, lastb);
                cap[beat] = out_w;
                if (lastb) begin
                    done = 1;
                    if (chain) begin
                        in_valid = 1'b1; in_mode = nmode; in_msg = nmsg;
                    end
                end
                beat++;
            end
            stalled = !out_ready; pw = out_w; pt = out_t;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        if (!done) chk("collect_timeout", beat, ref_n);
    endtask

    task automatic run_block(input logic [2:0] mode, input logic [1023:0] msg, input int rdy_pct);
        build_model(mode, msg);
        offer(mode, msg);
        collect(rdy_pct, 0, 3'd0, '0);
        chk("idle_after_last", out_valid, 0);
    endtask

    task automatic advance_to(input int target);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && out_t != 7'(target); cyc++) begin
            @(posedge clk); #1;
        end
        chk("reach_t", out_t, target);
    endtask

    logic [1023:0] abc32, abc64, m1, m2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{M_256, 0,  64'h61626380};
        vecs[1] = '{M_256, 1,  64'h0};
        vecs[2] = '{M_256, 15, 64'h18};
        vecs[3] = '{M_256, 16, 64'h61626380};
        vecs[4] = '{M_256, 17, 64'h000F0000};
        vecs[5] = '{M_SHA1, 16, 64'hC2C4C700};
        vecs[6] = '{M_SHA1, 17, 64'h0};
        vecs[7] = '{M_512, 0,  64'h6162638000000000};
        vecs[8] = '{M_512, 15, 64'h18};
        vecs[9] = '{M_512, 16, 64'h6162638000000000};

        abc32 = '0; abc32[511:480] = 32'h61626380; abc32[31:0] = 32'h18;
        abc64 = '0; abc64[1023:960] = 64'h6162638000000000; abc64[63:0] = 64'h18;

        rst = 1'b1; in_valid = 0; in_mode = 0; in_msg = '0; abort = 0; out_ready = 0;
        b_in_valid = 0; b_in_mode = 0; b_in_msg = '0; b_abort = 0; b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_t", out_t, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err, 0);
        chk("rst_out_w", out_w, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer blocks
        run_block(M_256, abc32, 100);  apply_table(M_256);
        run_block(M_SHA1, abc32, 100); apply_table(M_SHA1);
        run_block(M_512, abc64, 100);  apply_table(M_512);

        // Random blocks in every supported mode with random back-pressure
        for (int m = 0; m < 7; m++)
            run_block(3'(m), rand_msg(), 60);

        // Back-to-back: new block offered on the final handshake
        m1 = rand_msg(); m2 = rand_msg();
        build_model(M_512, m1);
        offer(M_512, m1);
        collect(50, 1, M_256, m2);
        build_model(M_256, m2);
        collect(50, 0, 3'd0, '0);
        chk("idle_after_chain", out_valid, 0);

        // Unsupported mode 7
        in_valid = 1; in_mode = 3'd7; in_msg = rand_msg();
        #1 chk("bad_in_ready", in_ready, 1);
        @(posedge clk); #1; in_valid = 0;
        chk("bad_err", err, 1);
        chk("bad_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("bad_err_pulse", err, 0);
        chk("bad_ready_after", in_ready, 1);
        chk("bad_valid_after", out_valid, 0);

        // SHA-512 on an instance built without the 64-bit datapath
        b_in_valid = 1; b_in_mode = M_512; b_in_msg = abc64;
        #1 chk("n512_ready", b_in_ready, 1);
        @(posedge clk); #1; b_in_valid = 0;
        chk("n512_err", b_err, 1);
        chk("n512_valid", b_out_valid, 0);
        @(posedge clk); #1;
        chk("n512_err_pulse", b_err, 0);
        chk("n512_ready_after", b_in_ready, 1);
        chk("n512_valid_after", b_out_valid, 0);
        // SHA-256 still works there
        b_in_valid = 1; b_in_mode = M_256; b_in_msg = abc32;
        @(posedge clk); #1; b_in_valid = 0;
        chk("n512_256_valid", b_out_valid, 1);
        chk("n512_256_w0", b_out_w, 64'h61626380);
        chk("n512_256_err", b_err, 0);

        // Abort at t=30
        m1 = rand_msg();
        build_model(M_256, m1);
        offer(M_256, m1);
        advance_to(30);
        chk("pre_abort_w", out_w, ref_w[30]);
        abort = 1;
        @(posedge clk); #1; abort = 0;
        chk("abort_valid", out_valid, 0);
        chk("abort_t", out_t, 0);
        // abort wins over a same-cycle offer
        in_valid = 1; in_mode = M_256; in_msg = m1; abort = 1;
        @(posedge clk); #1; in_valid = 0; abort = 0;
        chk("abort_drop_offer", out_valid, 0);

        // Reset at t=10
        m1 = rand_msg();
        build_model(M_512, m1);
        offer(M_512, m1);
        advance_to(10);
        rst = 1;
        @(posedge clk); #1; rst = 0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_t", out_t, 0);
        chk("rst_mid_w", out_w, 0);
        chk("rst_mid_ready", in_ready, 1);
        run_block(M_512, rand_msg(), 70);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
